// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared state encoding, vector constants and the gate reference model
// for the AND gate test sequencer.
package gate_test_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
    localparam int VEC_W    = 2;
    localparam int NUM_VECS = 4;
    function automatic logic exp_and(input logic a, input logic b);
        return a & b;
    endfunction
endpackage

// File: rtl/and_gate_test_ctrl_vec_gen.sv
// gate_test_vec_gen: walks the vector index 0..3 once per pass and flags the final
// vector of the final pass.
module gate_test_vec_gen
    import gate_test_pkg::*;
#(
    parameter int NUM_PASSES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [VEC_W-1:0] o_vec,
    output logic             o_last
);
    localparam int PW = NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1;
    logic [VEC_W-1:0] r_vec;
    logic [PW-1:0]    r_pass;
    logic             w_wrap;
    assign w_wrap = r_vec == VEC_W'(NUM_VECS - 1);
    assign o_vec  = r_vec;
    assign o_last = w_wrap && r_pass == PW'(NUM_PASSES - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vec  <= '0;
            r_pass <= '0;
        end else if (i_clear) begin
            r_vec  <= '0;
            r_pass <= '0;
        end else if (i_advance) begin
            r_vec  <= w_wrap ? '0 : r_vec + 1'b1;
            r_pass <= w_wrap ? r_pass + 1'b1 : r_pass;
        end
    end
endmodule

// File: rtl/and_gate_test_ctrl.sv
// and_gate_test_ctrl: sweeps the AND gate through all operand pairs, samples its output
// after a settle interval and accumulates an error count and pass/fail verdict.
module and_gate_test_ctrl
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             output1,
    output logic             input1,
    output logic             input2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [VEC_W-1:0] first_fail_vec
);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    state_t           r_state;
    logic [SW-1:0]    r_settle;
    logic [VEC_W-1:0] w_vec;
    logic [VEC_W-1:0] w_next_vec;
    logic             w_last;
    logic             w_clear;
    logic             w_advance;
    logic             w_miss;
    logic [ERR_W-1:0] w_err_next;
    assign w_clear    = start && (r_state == IDLE || r_state == DONE);
    assign w_advance  = r_state == CHECK && !w_last;
    assign w_miss     = r_state == CHECK && output1 != exp_and(w_vec[1], w_vec[0]);
    assign w_err_next = (w_miss && err_count != '1) ? err_count + 1'b1 : err_count;
    assign w_next_vec = w_vec + 1'b1;

    gate_test_vec_gen #(.NUM_PASSES(NUM_PASSES)) u_vec_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_vec     (w_vec),
        .o_last    (w_last)
    );

    // Operands are loaded on DRIVE entry so they hold steady through the CHECK sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_settle         <= '0;
            input1           <= 1'b0;
            input2           <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: if (start) begin
                    r_state          <= DRIVE;
                    r_settle         <= '0;
                    {input1, input2} <= 2'b00;
                    busy             <= 1'b1;
                    done             <= 1'b0;
                    pass             <= 1'b0;
                    err_count        <= '0;
                    first_fail_valid <= 1'b0;
                    first_fail_vec   <= '0;
                end
                DRIVE: begin
                    if (r_settle == SW'(SETTLE_CYCLES - 1)) r_state <= CHECK;
                    else r_settle <= r_settle + 1'b1;
                end
                CHECK: begin
                    err_count <= w_err_next;
                    if (w_miss && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_vec   <= w_vec;
                    end
                    if (w_last) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= w_err_next == '0;
                    end else begin
                        r_state          <= DRIVE;
                        r_settle         <= '0;
                        {input1, input2} <= w_next_vec;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_and_gate_test_ctrl.sv
// tb_and_gate_test_ctrl: directed scenarios for the AND gate sequencer with good,
// OR-substituted and stuck-at-0 gate models across three parameter sets.
module tb_and_gate_test_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [1:0] mode = 2'd0;
    int         n_checks = 0, n_fail = 0;

    logic       in1_a, in2_a, busy_a, done_a, pass_a, ffv_a, gate_a;
    logic [7:0] err_a;
    logic [1:0] ffvec_a;
    logic       in1_b, in2_b, busy_b, done_b, pass_b, ffv_b;
    logic [7:0] err_b;
    logic [1:0] ffvec_b;
    logic       in1_c, in2_c, busy_c, done_c, pass_c, ffv_c;
    logic [1:0] err_c;
    logic [1:0] ffvec_c;

    always #5 clk = ~clk;

    // mode 0: good AND gate, 1: OR gate, 2: output stuck at 0
    assign gate_a = mode == 2'd0 ? (in1_a & in2_a) : mode == 2'd1 ? (in1_a | in2_a) : 1'b0;

    and_gate_test_ctrl dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .output1(gate_a),
        .input1(in1_a), .input2(in2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
    );

    and_gate_test_ctrl #(.SETTLE_CYCLES(1), .NUM_PASSES(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .output1(1'b0),
        .input1(in1_b), .input2(in2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
    );

    and_gate_test_ctrl #(.ERR_W(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .output1(in1_c | in2_c),
        .input1(in1_c), .input2(in2_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_fail_valid(ffv_c), .first_fail_vec(ffvec_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({in1_a, in2_a, busy_a, done_a, pass_a, ffv_a, ffvec_a, err_a} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_a: outputs=%h required 0", {in1_a, in2_a, busy_a, done_a, pass_a, ffv_a, ffvec_a, err_a});
        end
        n_checks++;
        if ({busy_b, done_b, err_b, busy_c, done_c, err_c} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_bc: outputs=%h required 0", {busy_b, done_b, err_b, busy_c, done_c, err_c});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_and_pass();
        int n = 0;
        mode = 2'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_checks++;
        if ({busy_a, done_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL and_start_busy: busy,done=%b required 10", {busy_a, done_a});
        end
        while (!done_a && n < 200) begin
            tick();
            n++;
            if (n == 2 || n == 3 || n == 9) begin
                n_checks++;
                if ({in1_a, in2_a} !== (n == 2 ? 2'b00 : n == 3 ? 2'b01 : 2'b11)) begin
                    n_fail++;
                    $display("FAIL and_operands@%0d: got %b", n, {in1_a, in2_a});
                end
            end
            if (!done_a && busy_a !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL and_busy@%0d: busy=%b required 1", n, busy_a);
            end
        end
        n_checks++;
        if (n !== 48) begin
            n_fail++;
            $display("FAIL and_latency: %0d cycles required 48", n);
        end
        n_checks++;
        if ({busy_a, pass_a, ffv_a, err_a} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL and_result: busy=%b pass=%b ffv=%b err=%0d required 0 1 0 0", busy_a, pass_a, ffv_a, err_a);
        end
        repeat (5) tick();
        n_checks++;
        if ({done_a, pass_a, err_a} !== {1'b1, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL and_hold: done=%b pass=%b err=%0d required 1 1 0", done_a, pass_a, err_a);
        end
    endtask

    task automatic test_or_model();
        int n = 0;
        mode = 2'd1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        while (!done_a && n < 200) begin
            tick();
            n++;
            if (n == 5) begin
                n_checks++;
                if ({ffv_a, err_a} !== {1'b0, 8'd0}) begin
                    n_fail++;
                    $display("FAIL or_before_check: ffv=%b err=%0d required 0 0", ffv_a, err_a);
                end
            end
            if (n == 6) begin
                n_checks++;
                if ({ffv_a, ffvec_a, err_a} !== {1'b1, 2'b01, 8'd1}) begin
                    n_fail++;
                    $display("FAIL or_first_miss: ffv=%b vec=%b err=%0d required 1 01 1", ffv_a, ffvec_a, err_a);
                end
            end
        end
        n_checks++;
        if ({n == 48, pass_a, ffv_a, ffvec_a, err_a} !== {1'b1, 1'b0, 1'b1, 2'b01, 8'd8}) begin
            n_fail++;
            $display("FAIL or_result: cycles=%0d pass=%b ffv=%b vec=%b err=%0d required 48 0 1 01 8", n, pass_a, ffv_a, ffvec_a, err_a);
        end
    endtask

    task automatic test_stuck_small();
        int n = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        while (!done_b && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 24) begin
            n_fail++;
            $display("FAIL stuck_latency: %0d cycles required 24", n);
        end
        n_checks++;
        if ({pass_b, ffv_b, ffvec_b, err_b, busy_b} !== {1'b0, 1'b1, 2'b11, 8'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL stuck_result: pass=%b ffv=%b vec=%b err=%0d busy=%b required 0 1 11 3 0", pass_b, ffv_b, ffvec_b, err_b, busy_b);
        end
    endtask

    task automatic test_saturate();
        int n = 0;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        while (!done_c && n < 200) begin
            tick();
            n++;
            if (n == 18) begin
                n_checks++;
                if (err_c !== 2'd3) begin
                    n_fail++;
                    $display("FAIL sat_reach: err=%0d required 3", err_c);
                end
            end
        end
        n_checks++;
        if ({n == 48, pass_c, err_c, ffvec_c} !== {1'b1, 1'b0, 2'd3, 2'b01}) begin
            n_fail++;
            $display("FAIL sat_result: cycles=%0d pass=%b err=%0d vec=%b required 48 0 3 01", n, pass_c, err_c, ffvec_c);
        end
    endtask

    task automatic test_start_held();
        int n = 0;
        mode = 2'd1;
        start_a = 1'b1;
        tick();
        while (!done_a && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if ({n == 48, err_a} !== {1'b1, 8'd8}) begin
            n_fail++;
            $display("FAIL held_single_run: cycles=%0d err=%0d required 48 8", n, err_a);
        end
        tick();
        n_checks++;
        if ({done_a, busy_a, pass_a, ffv_a, err_a, in1_a, in2_a} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL held_restart_clear: done=%b busy=%b ffv=%b err=%0d ops=%b required 0 1 0 0 00", done_a, busy_a, ffv_a, err_a, {in1_a, in2_a});
        end
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if ({n == 48, err_a} !== {1'b1, 8'd8}) begin
            n_fail++;
            $display("FAIL held_rerun: cycles=%0d err=%0d required 48 8", n, err_a);
        end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        mode = 2'd1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (17) tick();
        n_checks++;
        if ({busy_a, in1_a, in2_a, err_a} !== {1'b1, 2'b01, 8'd2}) begin
            n_fail++;
            $display("FAIL mid_before_reset: busy=%b ops=%b err=%0d required 1 01 2", busy_a, {in1_a, in2_a}, err_a);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({in1_a, in2_a, busy_a, done_a, pass_a, ffv_a, ffvec_a, err_a} !== 15'd0) begin
            n_fail++;
            $display("FAIL mid_async_reset: outputs=%h required 0", {in1_a, in2_a, busy_a, done_a, pass_a, ffv_a, ffvec_a, err_a});
        end
        tick();
        reset_n = 1'b1;
        tick();
        mode = 2'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        while (!done_a && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if ({n == 48, pass_a, err_a} !== {1'b1, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL mid_full_rerun: cycles=%0d pass=%b err=%0d required 48 1 0", n, pass_a, err_a);
        end
    endtask

    initial begin
        test_reset();
        test_and_pass();
        test_or_model();
        test_stuck_small();
        test_saturate();
        test_start_held();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
